ask_frame_scheduler: RTL and testbench
======================================

# ask_frame_scheduler

Sequences one ASK transmission frame for the DDS output path. The frame consists of an alternating preamble, then FRAME_BYTES payload bytes read MSB-first from the MNIST byte ROM, then a silent guard gap. The block drives the bit_input of the DA wave sender and, optionally, mirrors every payload byte to the UART transmitter. It sits between the key/mode logic (start/abort pulses) and the ROM, DA and UART blocks, all in the 20 MHz domain.

## Interface
- BIT_CYCLES, 20000: clocks per transmitted bit (1 kbit/s); must be ≥ 4.
- PREAMBLE_BITS, 16: number of preamble bits, alternating 1,0,1,0…; must be ≥ 1.
- FRAME_BYTES, 784: number of payload bytes, fetched from ROM addresses 0..FRAME_BYTES-1.
- GAP_CYCLES, 200000: length of the post-frame guard interval in clocks; must be ≥ 1.
- clk_20m  in  1  system clock, 20 MHz.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to send a frame; ignored unless IDLE.
- abort  in  1  one-cycle request to cancel; valid in any state.
- rom_addr  out  17  byte ROM address.
- rom_data  in  8  ROM data; valid 2 cycles after rom_addr changes.
- bit_out  out  1  current ASK bit, to the DA bit_input.
- bit_valid  out  1  high during PREAMBLE and PAYLOAD.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame completes normally.
- byte_idx  out  10  index of the payload byte currently shifting.
- uart_tx_en  out  1  one-cycle byte strobe to the UART TX.
- uart_tx_data  out  8  byte to transmit over UART.
- uart_tx_busy  in  1  UART TX busy flag.

## Operation
- States:
  - IDLE → PREAMBLE on start && !abort.
  - PREAMBLE → PAYLOAD after PREAMBLE_BITS bits.
  - PAYLOAD → GAP after the last bit of the last byte.
  - GAP → IDLE after GAP_CYCLES clocks; done pulses on that transition.
- Abort: in any non-IDLE state, abort moves the block to IDLE on the next edge, with no done pulse. bit_out and bit_valid go 0 and byte_idx goes to 0.
- Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- A bit counter runs 0..BIT_CYCLES-1; a bit boundary occurs when it wraps.
- Preamble: bit k is 1 for even k and 0 for odd k.
- Prefetch:
  - At counter==0 of the final preamble bit, or of bit 0 of the last shifted byte, rom_addr is set to the next byte index.
  - At counter==2 the ROM byte is captured into a prefetch register.
  - At the following boundary that register loads the shift register.
- Payload bits are sent MSB first.
- byte_idx increments when a new byte loads into the shift register; it wraps to 0 only on a return to IDLE.
- GAP: bit_out=0, bit_valid=0, busy=1.
- While busy, start is ignored.

## Timing
- Reset values: bit_out 0, bit_valid 0, busy 0, done 0, rom_addr 0, byte_idx 0, uart_tx_en 0, uart_tx_data 0. State goes to IDLE and all counters clear.
- Start latency: bit_out=1, bit_valid=1 and busy=1 are registered on the first edge after start is sampled.
- Every bit lasts exactly BIT_CYCLES clocks, except for mirror stalls (see Configuration).
- Total frame length: BIT_CYCLES×(PREAMBLE_BITS+8×FRAME_BYTES) + GAP_CYCLES clocks from busy rising to done.
- done is asserted in the same cycle that busy falls.
- An assertion of rst_n mid-frame forces reset values immediately (asynchronous); no done pulse is produced.

## Configuration
- ASK_UART_MIRROR_EN defined:
  - At each byte-load boundary, if uart_tx_busy=0, the block pulses uart_tx_en for 1 cycle with uart_tx_data = the byte just loaded.
  - If uart_tx_busy=1 at that boundary, the preceding bit is held, extended one clock at a time, until uart_tx_busy=0. The load and the strobe then occur together.
  - abort during a stall behaves as in any other state.
- ASK_UART_MIRROR_EN not defined: uart_tx_en and uart_tx_data are held at 0, uart_tx_busy is ignored, and bit timing is never stretched.

## Test plan
Bench parameters for all scenarios: BIT_CYCLES=8, PREAMBLE_BITS=4, FRAME_BYTES=2, GAP_CYCLES=10; ROM[0]=0xA5, ROM[1]=0x3C.
- Nominal frame: start pulse → bit_out sequence 1,0,1,0, then 10100101, then 00111100, each bit 8 clocks. bit_valid is high for 160 clocks, and done pulses 170 clocks after busy rises.
- Abort at clock 50: busy=0 and bit_out=0 on the next edge, no done pulse; a new start then produces the full nominal sequence again.
- Start during busy and simultaneous start+abort in IDLE: sequence unchanged, and the block stays IDLE respectively.
- Mirror (macro defined), uart_tx_busy=0: uart_tx_en pulses at clocks 32 and 96, with data 0xA5 and 0x3C. Total length remains 170 clocks.
- Mirror stall: uart_tx_busy held at 1 for 5 clocks around the byte-1 boundary → the last bit of byte 0 lasts 13 clocks. The 0x3C strobe fires on release, and done arrives at 175 clocks.
- Reset asserted mid-payload → all outputs take their reset values immediately; after release, the block stays IDLE with no spurious done.

Source files
------------

// File: rtl/ask_frame_scheduler.sv
// ASK frame sequencer: alternating preamble, MSB-first ROM payload, silent guard gap.
// Define ASK_UART_MIRROR_EN to mirror each payload byte to the UART TX, with bit stretching while it is busy.
module ask_frame_scheduler #(
  parameter int BIT_CYCLES    = 20000,
  parameter int PREAMBLE_BITS = 16,
  parameter int FRAME_BYTES   = 784,
  parameter int GAP_CYCLES    = 200000
) (
  input  logic        clk_20m,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        busy,
  output logic        done,
  output logic [9:0]  byte_idx,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy
);

  localparam int BC_W  = $clog2(BIT_CYCLES + 1);
  localparam int PB_W  = $clog2(PREAMBLE_BITS + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BIT_CYCLES - 1);
  localparam logic [PB_W-1:0]  PB_LAST  = PB_W'(PREAMBLE_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [9:0]       FB_LAST  = 10'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  logic stall_s;
`ifdef ASK_UART_MIRROR_EN
  localparam logic MIRROR_EN = 1'b1;
  assign stall_s = uart_tx_busy;
`else
  localparam logic MIRROR_EN = 1'b0;
  logic unused_busy_s;
  assign stall_s       = 1'b0;
  assign unused_busy_s = uart_tx_busy;
`endif

  state_t            state_r, state_s;
  logic [BC_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
  logic [PB_W-1:0]   pre_idx_r, pre_idx_s;
  logic [2:0]        bit_in_byte_r, bit_in_byte_s;
  logic [6:0]        shift_r, shift_s;
  logic [7:0]        prefetch_r, prefetch_s;
  logic [9:0]        byte_idx_r, byte_idx_s;
  logic [16:0]       rom_addr_r, rom_addr_s;
  logic              bit_out_r, bit_out_s;
  logic              bit_valid_r, bit_valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              uart_tx_en_r, uart_tx_en_s;
  logic [7:0]        uart_tx_data_r, uart_tx_data_s;
  logic              load_s;

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_s        = state_r;
    bit_cnt_s      = bit_cnt_r;
    gap_cnt_s      = gap_cnt_r;
    pre_idx_s      = pre_idx_r;
    bit_in_byte_s  = bit_in_byte_r;
    shift_s        = shift_r;
    prefetch_s     = prefetch_r;
    byte_idx_s     = byte_idx_r;
    rom_addr_s     = rom_addr_r;
    bit_out_s      = bit_out_r;
    bit_valid_s    = bit_valid_r;
    busy_s         = busy_r;
    done_s         = 1'b0;
    uart_tx_en_s   = 1'b0;
    uart_tx_data_s = uart_tx_data_r;
    load_s         = 1'b0;

    if (abort && (state_r != ST_IDLE)) begin
      state_s       = ST_IDLE;
      bit_cnt_s     = '0;
      gap_cnt_s     = '0;
      pre_idx_s     = '0;
      bit_in_byte_s = 3'd0;
      byte_idx_s    = 10'd0;
      rom_addr_s    = 17'd0;
      bit_out_s     = 1'b0;
      bit_valid_s   = 1'b0;
      busy_s        = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            state_s     = ST_PREAMBLE;
            bit_cnt_s   = '0;
            pre_idx_s   = '0;
            byte_idx_s  = 10'd0;
            rom_addr_s  = 17'd0;
            bit_out_s   = 1'b1;
            bit_valid_s = 1'b1;
            busy_s      = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if ((bit_cnt_r == BC_LAST) && (pre_idx_r == PB_LAST)) begin
            load_s = 1'b1;
          end else if (bit_cnt_r == BC_LAST) begin
            bit_cnt_s = '0;
            pre_idx_s = pre_idx_r + PB_W'(1);
            bit_out_s = pre_idx_r[0];
            // Byte 0 address is presented as the final preamble bit begins.
            if ((pre_idx_r + PB_W'(1)) == PB_LAST) begin
              rom_addr_s = 17'd0;
            end else begin
              rom_addr_s = rom_addr_r;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BC_W'(1);
            if ((pre_idx_r == PB_LAST) && (bit_cnt_r == BC_W'(2))) begin
              prefetch_s = rom_data;
            end else begin
              prefetch_s = prefetch_r;
            end
          end
        end
        ST_PAYLOAD: begin
          if ((bit_cnt_r == BC_LAST) && (bit_in_byte_r == 3'd7) && (byte_idx_r == FB_LAST)) begin
            state_s     = ST_GAP;
            bit_cnt_s   = '0;
            gap_cnt_s   = '0;
            bit_out_s   = 1'b0;
            bit_valid_s = 1'b0;
          end else if ((bit_cnt_r == BC_LAST) && (bit_in_byte_r == 3'd7)) begin
            load_s = 1'b1;
          end else if (bit_cnt_r == BC_LAST) begin
            bit_cnt_s     = '0;
            shift_s       = {shift_r[5:0], 1'b0};
            bit_out_s     = shift_r[6];
            bit_in_byte_s = bit_in_byte_r + 3'd1;
            if ((bit_in_byte_r == 3'd6) && (byte_idx_r != FB_LAST)) begin
              rom_addr_s = {7'd0, byte_idx_r} + 17'd1;
            end else begin
              rom_addr_s = rom_addr_r;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + BC_W'(1);
            if ((bit_in_byte_r == 3'd7) && (bit_cnt_r == BC_W'(2))) begin
              prefetch_s = rom_data;
            end else begin
              prefetch_s = prefetch_r;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_s    = ST_IDLE;
            gap_cnt_s  = '0;
            bit_cnt_s  = '0;
            pre_idx_s  = '0;
            byte_idx_s = 10'd0;
            rom_addr_s = 17'd0;
            busy_s     = 1'b0;
            done_s     = 1'b1;
          end else begin
            gap_cnt_s = gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      // A busy UART holds the counter at the boundary, stretching the current bit.
      if (load_s && stall_s) begin
        bit_cnt_s = bit_cnt_r;
      end else if (load_s) begin
        state_s        = ST_PAYLOAD;
        bit_cnt_s      = '0;
        shift_s        = prefetch_r[6:0];
        bit_out_s      = prefetch_r[7];
        bit_in_byte_s  = 3'd0;
        byte_idx_s     = (state_r == ST_PAYLOAD) ? (byte_idx_r + 10'd1) : byte_idx_r;
        uart_tx_en_s   = MIRROR_EN;
        uart_tx_data_s = MIRROR_EN ? prefetch_r : 8'd0;
      end else begin
        uart_tx_en_s = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      bit_cnt_r      <= '0;
      gap_cnt_r      <= '0;
      pre_idx_r      <= '0;
      bit_in_byte_r  <= 3'd0;
      shift_r        <= 7'd0;
      prefetch_r     <= 8'd0;
      byte_idx_r     <= 10'd0;
      rom_addr_r     <= 17'd0;
      bit_out_r      <= 1'b0;
      bit_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      uart_tx_en_r   <= 1'b0;
      uart_tx_data_r <= 8'd0;
    end else begin
      state_r        <= state_s;
      bit_cnt_r      <= bit_cnt_s;
      gap_cnt_r      <= gap_cnt_s;
      pre_idx_r      <= pre_idx_s;
      bit_in_byte_r  <= bit_in_byte_s;
      shift_r        <= shift_s;
      prefetch_r     <= prefetch_s;
      byte_idx_r     <= byte_idx_s;
      rom_addr_r     <= rom_addr_s;
      bit_out_r      <= bit_out_s;
      bit_valid_r    <= bit_valid_s;
      busy_r         <= busy_s;
      done_r         <= done_s;
      uart_tx_en_r   <= uart_tx_en_s;
      uart_tx_data_r <= uart_tx_data_s;
    end
  end

  assign rom_addr     = rom_addr_r;
  assign bit_out      = bit_out_r;
  assign bit_valid    = bit_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign byte_idx     = byte_idx_r;
  assign uart_tx_en   = uart_tx_en_r;
  assign uart_tx_data = uart_tx_data_r;

endmodule

// File: tb/tb_ask_frame_scheduler.sv
// Directed bench for ask_frame_scheduler with a small frame (8 clk/bit, 4 preamble bits, 2 bytes, 10 clk gap).
// Mirror scenarios run when ASK_UART_MIRROR_EN is defined.
module tb_ask_frame_scheduler;

  logic        clk_20m = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        uart_tx_busy = 1'b0;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  rom_q1;
  logic        bit_out, bit_valid, busy, done, uart_tx_en;
  logic [9:0]  byte_idx;
  logic [7:0]  uart_tx_data;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_bytes [2] = '{8'hA5, 8'h3C};

  ask_frame_scheduler #(
    .BIT_CYCLES(8), .PREAMBLE_BITS(4), .FRAME_BYTES(2), .GAP_CYCLES(10)
  ) dut (
    .clk_20m(clk_20m), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data), .bit_out(bit_out),
    .bit_valid(bit_valid), .busy(busy), .done(done), .byte_idx(byte_idx),
    .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy)
  );

  always #25 clk_20m = ~clk_20m;

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    case (a)
      17'd0:   return 8'hA5;
      17'd1:   return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Two-cycle ROM read latency.
  always @(posedge clk_20m) begin
    rom_q1   <= rom_byte(rom_addr);
    rom_data <= rom_q1;
  end

  // Expected bit at cycle c after busy rises; s = stall clocks added to the last bit of byte 0.
  function automatic logic exp_bit(input int c, input int s);
    int k, j;
    logic [7:0] b;
    k = c;
    if (s > 0 && k >= 96 && k < 96 + s) k = 95;
    else if (k >= 96 + s) k = k - s;
    if (k < 32) return ((k / 8) % 2 == 0);
    if (k < 160) begin
      j = (k - 32) / 8;
      b = exp_bytes[j / 8];
      return b[7 - (j % 8)];
    end
    return 1'b0;
  endfunction

  task automatic start_frame();
    @(negedge clk_20m);
    start = 1'b1;
    @(posedge clk_20m);
    @(negedge clk_20m);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_20m);
    @(negedge clk_20m);
    n_cmp++; if (bit_out !== 1'b0)      begin n_err++; $display("FAIL reset bit_out got %b exp 0", bit_out); end
    n_cmp++; if (bit_valid !== 1'b0)    begin n_err++; $display("FAIL reset bit_valid got %b exp 0", bit_valid); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0)         begin n_err++; $display("FAIL reset done got %b exp 0", done); end
    n_cmp++; if (rom_addr !== 17'd0)    begin n_err++; $display("FAIL reset rom_addr got %0d exp 0", rom_addr); end
    n_cmp++; if (byte_idx !== 10'd0)    begin n_err++; $display("FAIL reset byte_idx got %0d exp 0", byte_idx); end
    n_cmp++; if (uart_tx_en !== 1'b0)   begin n_err++; $display("FAIL reset uart_tx_en got %b exp 0", uart_tx_en); end
    n_cmp++; if (uart_tx_data !== 8'd0) begin n_err++; $display("FAIL reset uart_tx_data got %h exp 00", uart_tx_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_20m);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got %b exp 0", busy); end
  endtask

  // Full frame check; poke_at >= 0 re-pulses start mid-frame, which must be ignored.
  task automatic test_nominal(input int poke_at);
    logic e_en;
    start_frame();
    for (int c = 0; c <= 171; c++) begin
      start = (c == poke_at);
      n_cmp++; if (bit_out !== exp_bit(c, 0)) begin n_err++; $display("FAIL nominal bit_out c=%0d got %b exp %b", c, bit_out, exp_bit(c, 0)); end
      n_cmp++; if (bit_valid !== (c < 160)) begin n_err++; $display("FAIL nominal bit_valid c=%0d got %b exp %b", c, bit_valid, (c < 160)); end
      n_cmp++; if (busy !== (c < 170)) begin n_err++; $display("FAIL nominal busy c=%0d got %b exp %b", c, busy, (c < 170)); end
      n_cmp++; if (done !== (c == 170)) begin n_err++; $display("FAIL nominal done c=%0d got %b exp %b", c, done, (c == 170)); end
      n_cmp++; if (byte_idx !== ((c >= 96 && c < 170) ? 10'd1 : 10'd0)) begin n_err++; $display("FAIL nominal byte_idx c=%0d got %0d", c, byte_idx); end
`ifdef ASK_UART_MIRROR_EN
      e_en = (c == 32) || (c == 96);
      n_cmp++; if (uart_tx_en !== e_en) begin n_err++; $display("FAIL mirror uart_tx_en c=%0d got %b exp %b", c, uart_tx_en, e_en); end
      if (e_en) begin
        n_cmp++; if (uart_tx_data !== ((c == 32) ? 8'hA5 : 8'h3C)) begin n_err++; $display("FAIL mirror uart_tx_data c=%0d got %h", c, uart_tx_data); end
      end
`else
      e_en = 1'b0;
      n_cmp++; if (uart_tx_en !== e_en) begin n_err++; $display("FAIL nomirror uart_tx_en c=%0d got %b exp 0", c, uart_tx_en); end
      n_cmp++; if (uart_tx_data !== 8'd0) begin n_err++; $display("FAIL nomirror uart_tx_data c=%0d got %h exp 00", c, uart_tx_data); end
`endif
      @(negedge clk_20m);
    end
    start = 1'b0;
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk_20m);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk_20m);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (busy !== 1'b0 || bit_valid !== 1'b0) begin n_err++; $display("FAIL start_abort_idle c=%0d busy=%b bit_valid=%b exp 0/0", c, busy, bit_valid); end
      @(negedge clk_20m);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    start_frame();
    repeat (50) @(negedge clk_20m);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort pre busy got %b exp 1", busy); end
    abort = 1'b1;
    @(negedge clk_20m);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort busy got %b exp 0", busy); end
    n_cmp++; if (bit_out !== 1'b0)   begin n_err++; $display("FAIL abort bit_out got %b exp 0", bit_out); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL abort bit_valid got %b exp 0", bit_valid); end
    n_cmp++; if (byte_idx !== 10'd0) begin n_err++; $display("FAIL abort byte_idx got %0d exp 0", byte_idx); end
    seen_done = 0;
    for (int c = 0; c < 200; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
      @(negedge clk_20m);
    end
    n_cmp++; if (seen_done != 0) begin n_err++; $display("FAIL abort_quiet done/busy cycles got %0d exp 0", seen_done); end
    test_nominal(-1);
  endtask

`ifdef ASK_UART_MIRROR_EN
  task automatic test_mirror_stall();
    logic e_en;
    start_frame();
    for (int c = 0; c <= 176; c++) begin
      uart_tx_busy = (c >= 95 && c <= 99);
      e_en = (c == 32) || (c == 101);
      n_cmp++; if (bit_out !== exp_bit(c, 5)) begin n_err++; $display("FAIL stall bit_out c=%0d got %b exp %b", c, bit_out, exp_bit(c, 5)); end
      n_cmp++; if (bit_valid !== (c < 165)) begin n_err++; $display("FAIL stall bit_valid c=%0d got %b", c, bit_valid); end
      n_cmp++; if (busy !== (c < 175)) begin n_err++; $display("FAIL stall busy c=%0d got %b exp %b", c, busy, (c < 175)); end
      n_cmp++; if (done !== (c == 175)) begin n_err++; $display("FAIL stall done c=%0d got %b exp %b", c, done, (c == 175)); end
      n_cmp++; if (byte_idx !== ((c >= 101 && c < 175) ? 10'd1 : 10'd0)) begin n_err++; $display("FAIL stall byte_idx c=%0d got %0d", c, byte_idx); end
      n_cmp++; if (uart_tx_en !== e_en) begin n_err++; $display("FAIL stall uart_tx_en c=%0d got %b exp %b", c, uart_tx_en, e_en); end
      if (e_en) begin
        n_cmp++; if (uart_tx_data !== ((c == 32) ? 8'hA5 : 8'h3C)) begin n_err++; $display("FAIL stall uart_tx_data c=%0d got %h", c, uart_tx_data); end
      end
      @(negedge clk_20m);
    end
    uart_tx_busy = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    int seen;
    start_frame();
    repeat (110) @(negedge clk_20m);
    n_cmp++; if (byte_idx !== 10'd1) begin n_err++; $display("FAIL rstmid pre byte_idx got %0d exp 1", byte_idx); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rstmid busy got %b exp 0", busy); end
    n_cmp++; if (bit_out !== 1'b0)   begin n_err++; $display("FAIL rstmid bit_out got %b exp 0", bit_out); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rstmid bit_valid got %b exp 0", bit_valid); end
    n_cmp++; if (done !== 1'b0)      begin n_err++; $display("FAIL rstmid done got %b exp 0", done); end
    n_cmp++; if (rom_addr !== 17'd0) begin n_err++; $display("FAIL rstmid rom_addr got %0d exp 0", rom_addr); end
    n_cmp++; if (byte_idx !== 10'd0) begin n_err++; $display("FAIL rstmid byte_idx got %0d exp 0", byte_idx); end
    n_cmp++; if (uart_tx_en !== 1'b0 || uart_tx_data !== 8'd0) begin n_err++; $display("FAIL rstmid uart got %b/%h exp 0/00", uart_tx_en, uart_tx_data); end
    @(negedge clk_20m);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_20m);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmid_quiet done/busy cycles got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_nominal(-1);
    test_nominal(20);
    test_nominal(165);
    test_start_abort_idle();
    test_abort();
`ifdef ASK_UART_MIRROR_EN
    test_mirror_stall();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
